// File: rtl/clock24_pkg.sv
// Shared definitions for the 24-hour clock front end.
// Holds the key count, the key index map (bit position in nBIN/BOUT) and the
// per-key press FSM state type used by the debounce channels.
package clock24_pkg;

   localparam int NKEYS      = 3;

   localparam int KEY_ADJUST = 0;
   localparam int KEY_SELECT = 1;
   localparam int KEY_MODE   = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } key_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One key channel: 2-flop synchronizer, tick-sampled debouncer, press FSM
// and a registered one-cycle press pulse.
// Build option: AUTO_REPEAT_EN adds the REPEAT state, the hold/repeat tick
// counters and the RPT_DELAY/RPT_PERIOD/RPT_EN parameters; without it every
// accepted press yields exactly one pulse.
// Ports:
//   clk_i    system clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   tick_i   shared sample strobe, one clk_i cycle wide
//   nkey_i   raw key, active-low, asynchronous to clk_i
//   pulse_o  press pulse, active-high, one clk_i cycle
//
// state  | meaning
// IDLE   | key released (debounced)
// HELD   | key pressed, press pulse already issued
// REPEAT | key held past RPT_DELAY, pulse every RPT_PERIOD ticks
module btn_debounce_ch
   import clock24_pkg::*;
#(
   parameter int DB_SAMPLES = 2
`ifdef AUTO_REPEAT_EN
   ,
   parameter int RPT_DELAY  = 20,
   parameter int RPT_PERIOD = 4,
   parameter bit RPT_EN     = 1'b0
`endif
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic tick_i,
   input  logic nkey_i,
   output logic pulse_o
);

   localparam int DB_W = $clog2(DB_SAMPLES + 1);

   logic [1:0]      sync_q;
   logic            synced;
   logic            stable_q, stable_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            accept_press, accept_release;
   key_state_e      state_q, state_d;
   logic            pulse_q, pulse_d;

`ifdef AUTO_REPEAT_EN
   // A zero delay is treated as one tick so the compare constant stays valid.
   localparam int RPT_DELAY_EFF  = (RPT_DELAY  < 1) ? 1 : RPT_DELAY;
   localparam int RPT_PERIOD_EFF = (RPT_PERIOD < 1) ? 1 : RPT_PERIOD;
   localparam int HD_W = $clog2(RPT_DELAY_EFF + 1);
   localparam int RP_W = $clog2(RPT_PERIOD_EFF + 1);

   logic [HD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [RP_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

   assign synced  = sync_q[1];
   assign pulse_o = pulse_q;

   // Debouncer. The accept strobes are combinational so the FSM acts on the
   // same tick that flips the stable level; this keeps press latency at
   // DB_SAMPLES ticks plus the output register.
   always_comb begin
      stable_d       = stable_q;
      db_cnt_d       = db_cnt_q;
      accept_press   = 1'b0;
      accept_release = 1'b0;
      if (tick_i) begin
         if (synced == stable_q) begin
            db_cnt_d = '0;
         end else if (db_cnt_q == DB_W'(DB_SAMPLES - 1)) begin
            stable_d       = synced;
            db_cnt_d       = '0;
            accept_press   = ~synced;
            accept_release = synced;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pulse_d = 1'b0;
`ifdef AUTO_REPEAT_EN
      hold_cnt_d = hold_cnt_q;
      rpt_cnt_d  = rpt_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept_press) begin
               state_d = HELD;
               pulse_d = 1'b1;
`ifdef AUTO_REPEAT_EN
               hold_cnt_d = '0;
`endif
            end
         end
         HELD: begin
            if (accept_release) begin
               state_d = IDLE;
            end
`ifdef AUTO_REPEAT_EN
            else if (RPT_EN && tick_i) begin
               if (hold_cnt_q == HD_W'(RPT_DELAY_EFF - 1)) begin
                  state_d   = REPEAT;
                  rpt_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
`endif
         end
`ifdef AUTO_REPEAT_EN
         REPEAT: begin
            if (accept_release) begin
               state_d = IDLE;
            end else if (tick_i) begin
               if (rpt_cnt_q == RP_W'(RPT_PERIOD_EFF - 1)) begin
                  pulse_d   = 1'b1;
                  rpt_cnt_d = '0;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + 1'b1;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q   <= 2'b11;
         stable_q <= 1'b1;
         db_cnt_q <= '0;
         state_q  <= IDLE;
         pulse_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], nkey_i};
         stable_q <= stable_d;
         db_cnt_q <= db_cnt_d;
         state_q  <= state_d;
         pulse_q  <= pulse_d;
      end
   end

`ifdef AUTO_REPEAT_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hold_cnt_q <= '0;
         rpt_cnt_q  <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         rpt_cnt_q  <= rpt_cnt_d;
      end
   end
`endif

endmodule

// File: rtl/btn_debounce_rpt.sv
// Push-button conditioning for the 24-hour clock: synchronizes and debounces
// the three raw active-low keys and emits one-cycle press pulses.
// Build option: AUTO_REPEAT_EN enables auto-repeat on the ADJUST key only;
// when undefined RPT_DELAY and RPT_PERIOD are accepted but have no effect.
// Ports:
//   CLK   system clock, rising edge
//   RST   asynchronous active-low reset
//   nBIN  raw keys, active-low; [2]=MODE [1]=SELECT [0]=ADJUST
//   BOUT  press pulses, active-high, one CLK cycle, same bit order
module btn_debounce_rpt
   import clock24_pkg::*;
#(
   parameter int TICK_DIV   = 1_250_000,
   parameter int DB_SAMPLES = 2,
   parameter int RPT_DELAY  = 20,
   parameter int RPT_PERIOD = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [NKEYS-1:0] nBIN,
   output logic [NKEYS-1:0] BOUT
);

   localparam int TD_W = $clog2(TICK_DIV);

   logic [TD_W-1:0] tick_cnt_q, tick_cnt_d;
   logic            tick;

   // Shared sample strobe: high during the cycle the count sits at TICK_DIV-1.
   assign tick       = (tick_cnt_q == TD_W'(TICK_DIV - 1));
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   for (genvar k = 0; k < NKEYS; k++) begin : g_ch
`ifdef AUTO_REPEAT_EN
      btn_debounce_ch #(
         .DB_SAMPLES (DB_SAMPLES),
         .RPT_DELAY  (RPT_DELAY),
         .RPT_PERIOD (RPT_PERIOD),
         .RPT_EN     (k == KEY_ADJUST)
      ) u_ch (
         .clk_i   (CLK),
         .rst_n_i (RST),
         .tick_i  (tick),
         .nkey_i  (nBIN[k]),
         .pulse_o (BOUT[k])
      );
`else
      btn_debounce_ch #(
         .DB_SAMPLES (DB_SAMPLES)
      ) u_ch (
         .clk_i   (CLK),
         .rst_n_i (RST),
         .tick_i  (tick),
         .nkey_i  (nBIN[k]),
         .pulse_o (BOUT[k])
      );
`endif
   end

endmodule

// File: tb/tb_btn_debounce_rpt.sv
// Self-checking bench for btn_debounce_rpt with TICK_DIV=4, DB_SAMPLES=2,
// RPT_DELAY=5, RPT_PERIOD=2. Expected pulses (value plus allowed cycle
// window) are queued when stimulus is applied; a negedge monitor queues every
// nonzero BOUT with its cycle number, and each scenario drains both queues.
module tb_btn_debounce_rpt;
   import clock24_pkg::*;

   logic       CLK = 1'b0;
   logic       RST;
   logic [2:0] nBIN;
   logic [2:0] BOUT;

   int cyc     = 0;
   int rel_cyc = 0;
   int checks  = 0;
   int errors  = 0;

   typedef struct {
      logic [2:0] val;
      int         lo;
      int         hi;
   } exp_t;

   typedef struct {
      logic [2:0] val;
      int         cyc;
   } act_t;

   exp_t exp_q[$];
   act_t act_q[$];

   btn_debounce_rpt #(
      .TICK_DIV   (4),
      .DB_SAMPLES (2),
      .RPT_DELAY  (5),
      .RPT_PERIOD (2)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .nBIN (nBIN),
      .BOUT (BOUT)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (BOUT !== 3'b000) act_q.push_back(act_t'{val: BOUT, cyc: cyc});
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Tick edges fall every 4 cycles after reset release (count 0,1,2,3).
   function automatic int next_tick(input int c);
      int t;
      t = c;
      while (((t - rel_cyc) % 4) != 0) t++;
      return t;
   endfunction

   task automatic test_reset();
      RST  = 1'b0;
      nBIN = 3'b111;
      for (int i = 0; i < 10; i++) begin
         step(1);
         checks++;
         if (BOUT !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold BOUT got %b want 000 at cycle %0d", BOUT, cyc);
         end
      end
      RST     = 1'b1;
      rel_cyc = cyc;
      step(100);
      checks++;
      if (act_q.size() !== 0) begin
         errors++;
         $display("FAIL reset_quiet pulse count got %0d want 0", act_q.size());
         act_q.delete();
      end
   endtask

   task automatic test_clean_press();
      int d;
      act_t a;
      exp_t e;
      d = cyc;
      nBIN[KEY_SELECT] = 1'b0;
      exp_q.push_back(exp_t'{val: 3'b010, lo: d + 7, hi: d + 11});
      step(40);
      nBIN[KEY_SELECT] = 1'b1;
      step(30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (act_q.size() == 0) begin
            errors++;
            $display("FAIL clean_press pulse got none want %b in [%0d,%0d]", e.val, e.lo, e.hi);
         end else begin
            a = act_q.pop_front();
            if (a.val !== e.val || a.cyc < e.lo || a.cyc > e.hi) begin
               errors++;
               $display("FAIL clean_press pulse got %b@%0d want %b in [%0d,%0d]", a.val, a.cyc, e.val, e.lo, e.hi);
            end
         end
      end
      checks++;
      if (act_q.size() !== 0) begin
         errors++;
         $display("FAIL clean_press extra pulses got %0d want 0", act_q.size());
         act_q.delete();
      end
   endtask

   task automatic test_bounce();
      int d;
      act_t a;
      exp_t e;
      d = cyc;
      exp_q.push_back(exp_t'{val: 3'b100, lo: d + 1, hi: d + 41});
      for (int i = 0; i < 10; i++) begin
         nBIN[KEY_MODE] = (i % 2 == 0) ? 1'b0 : 1'b1;
         step(3);
      end
      nBIN[KEY_MODE] = 1'b0;
      step(40);
      nBIN[KEY_MODE] = 1'b1;
      step(30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (act_q.size() == 0) begin
            errors++;
            $display("FAIL bounce pulse got none want %b in [%0d,%0d]", e.val, e.lo, e.hi);
         end else begin
            a = act_q.pop_front();
            if (a.val !== e.val || a.cyc < e.lo || a.cyc > e.hi) begin
               errors++;
               $display("FAIL bounce pulse got %b@%0d want %b in [%0d,%0d]", a.val, a.cyc, e.val, e.lo, e.hi);
            end
         end
      end
      checks++;
      if (act_q.size() !== 0) begin
         errors++;
         $display("FAIL bounce extra pulses got %0d want 0", act_q.size());
         act_q.delete();
      end
   endtask

   task automatic test_simultaneous();
      int d;
      act_t a;
      exp_t e;
      d = cyc;
      nBIN = 3'b000;
      exp_q.push_back(exp_t'{val: 3'b111, lo: d + 7, hi: d + 11});
      step(20);
      nBIN = 3'b111;
      step(30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (act_q.size() == 0) begin
            errors++;
            $display("FAIL simultaneous pulse got none want %b in [%0d,%0d]", e.val, e.lo, e.hi);
         end else begin
            a = act_q.pop_front();
            if (a.val !== e.val || a.cyc < e.lo || a.cyc > e.hi) begin
               errors++;
               $display("FAIL simultaneous pulse got %b@%0d want %b in [%0d,%0d]", a.val, a.cyc, e.val, e.lo, e.hi);
            end
         end
      end
      checks++;
      if (act_q.size() !== 0) begin
         errors++;
         $display("FAIL simultaneous extra pulses got %0d want 0", act_q.size());
         act_q.delete();
      end
   endtask

   // ADJUST and MODE held together for 60 ticks: only ADJUST may repeat.
   task automatic test_auto_repeat();
      int d;
      int acc;
      int r;
      int t2;
      act_t a;
      exp_t e;
      d    = cyc;
      nBIN = 3'b010;
      acc  = next_tick(d + 3) + 4;
      exp_q.push_back(exp_t'{val: 3'b101, lo: acc, hi: acc});
      step(240);
      nBIN = 3'b111;
      r    = cyc;
      t2   = next_tick(r + 3) + 4;
`ifdef AUTO_REPEAT_EN
      for (int t = acc + 28; t < t2; t += 8) begin
         exp_q.push_back(exp_t'{val: 3'b001, lo: t, hi: t});
      end
`endif
      step(40);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (act_q.size() == 0) begin
            errors++;
            $display("FAIL auto_repeat pulse got none want %b in [%0d,%0d]", e.val, e.lo, e.hi);
         end else begin
            a = act_q.pop_front();
            if (a.val !== e.val || a.cyc < e.lo || a.cyc > e.hi) begin
               errors++;
               $display("FAIL auto_repeat pulse got %b@%0d want %b in [%0d,%0d]", a.val, a.cyc, e.val, e.lo, e.hi);
            end
         end
      end
      checks++;
      if (act_q.size() !== 0) begin
         errors++;
         $display("FAIL auto_repeat extra pulses got %0d want 0 (release near cycle %0d)", act_q.size(), t2);
         act_q.delete();
      end
   endtask

   task automatic test_reset_mid_hold();
      int d;
      int acc;
      int s;
      int r;
      act_t a;
      exp_t e;
      d    = cyc;
      nBIN = 3'b110;
      acc  = next_tick(d + 3) + 4;
      exp_q.push_back(exp_t'{val: 3'b001, lo: acc, hi: acc});
      step(100);
      s = cyc;
`ifdef AUTO_REPEAT_EN
      // A repeat registered on edge s is wiped by the reset before it is seen.
      for (int t = acc + 28; t < s; t += 8) begin
         exp_q.push_back(exp_t'{val: 3'b001, lo: t, hi: t});
      end
`endif
      RST = 1'b0;
      repeat (3) begin
         #2;
         checks++;
         if (BOUT !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_hold BOUT in reset got %b want 000 at cycle %0d", BOUT, cyc);
         end
         step(1);
      end
      RST     = 1'b1;
      r       = cyc;
      rel_cyc = r;
      exp_q.push_back(exp_t'{val: 3'b001, lo: r + 8, hi: r + 8});
      step(20);
      nBIN = 3'b111;
      step(30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (act_q.size() == 0) begin
            errors++;
            $display("FAIL reset_mid_hold pulse got none want %b in [%0d,%0d]", e.val, e.lo, e.hi);
         end else begin
            a = act_q.pop_front();
            if (a.val !== e.val || a.cyc < e.lo || a.cyc > e.hi) begin
               errors++;
               $display("FAIL reset_mid_hold pulse got %b@%0d want %b in [%0d,%0d]", a.val, a.cyc, e.val, e.lo, e.hi);
            end
         end
      end
      checks++;
      if (act_q.size() !== 0) begin
         errors++;
         $display("FAIL reset_mid_hold extra pulses got %0d want 0", act_q.size());
         act_q.delete();
      end
   endtask

   initial begin
      RST  = 1'b0;
      nBIN = 3'b111;
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_auto_repeat();
      test_reset_mid_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
